// File: rtl/intersection_pkg.sv
// Shared state encoding, lamp decode and default phase timing for the
// two-approach intersection controller.
package intersection_pkg;

    localparam int GREEN_MIN_DEF = 8;
    localparam int GREEN_MAX_DEF = 20;
    localparam int YELLOW_T_DEF  = 3;
    localparam int ALLRED_T_DEF  = 2;
    localparam int WALK_T_DEF    = 6;
    localparam int CNT_W_DEF     = 5;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_NS_GRN = 3'd1,
        ST_NS_YEL = 3'd2,
        ST_NS_CLR = 3'd3,
        ST_EW_GRN = 3'd4,
        ST_EW_YEL = 3'd5,
        ST_EW_CLR = 3'd6
    } state_e;

    typedef struct packed {
        logic nsRed;
        logic nsYellow;
        logic nsGreen;
        logic ewRed;
        logic ewYellow;
        logic ewGreen;
    } lamps_t;

    // Moore lamp decode; anything outside the legal states shows everything dark.
    function automatic lamps_t decodeLamps(input state_e st);
        lamps_t l;
        l = '0;
        case (st)
            ST_NS_GRN: begin l.nsGreen  = 1'b1; l.ewRed = 1'b1; end
            ST_NS_YEL: begin l.nsYellow = 1'b1; l.ewRed = 1'b1; end
            ST_EW_GRN: begin l.ewGreen  = 1'b1; l.nsRed = 1'b1; end
            ST_EW_YEL: begin l.ewYellow = 1'b1; l.nsRed = 1'b1; end
            ST_NS_CLR,
            ST_EW_CLR: begin l.nsRed    = 1'b1; l.ewRed = 1'b1; end
            default:   l = '0;
        endcase
        return l;
    endfunction

    function automatic logic isClear(input state_e st);
        return (st == ST_NS_CLR) || (st == ST_EW_CLR);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase timer with synchronous clear and a terminal compare
// (count has reached or passed the supplied terminal value).
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rstN_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             reached_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign reached_o = (cnt_q >= term_i);

endmodule

// File: rtl/intersection_ctrl.sv
// Timer-driven Moore controller for NS/EW signal heads with a latched
// pedestrian walk served during the all-red clearance.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_DEF,
    parameter int GREEN_MAX = GREEN_MAX_DEF,
    parameter int YELLOW_T  = YELLOW_T_DEF,
    parameter int ALLRED_T  = ALLRED_T_DEF,
    parameter int WALK_T    = WALK_T_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] state_out
);

    state_e           state_q, state_d;
    logic             pedPend_q, pedPend_d;
    logic             walkAct_q, walkAct_d;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] term;
    logic             reached;
    logic             maxHit;
    logic             stateChange;
    lamps_t           lamps;

    // Terminal count for the current phase; in green it marks the minimum.
    always_comb begin
        term = '0;
        case (state_q)
            ST_NS_GRN, ST_EW_GRN: term = CNT_W'(GREEN_MIN - 1);
            ST_NS_YEL, ST_EW_YEL: term = CNT_W'(YELLOW_T - 1);
            ST_NS_CLR, ST_EW_CLR: term = walkAct_q ? CNT_W'(WALK_T - 1) : CNT_W'(ALLRED_T - 1);
            default:              term = '0;
        endcase
    end

    assign maxHit      = (timer == CNT_W'(GREEN_MAX - 1));
    assign stateChange = (state_d != state_q);

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk_i    (clk),
        .rstN_i   (reset),
        .clr_i    (stateChange),
        .term_i   (term),
        .cnt_o    (timer),
        .reached_o(reached)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:    if (enb) state_d = ST_EW_CLR;
            ST_NS_GRN: if (!enb || ((reached || maxHit) && (req_ew || pedPend_q))) state_d = ST_NS_YEL;
            ST_NS_YEL: if (reached) state_d = ST_NS_CLR;
            ST_NS_CLR: if (reached) state_d = enb ? ST_EW_GRN : ST_OFF;
            ST_EW_GRN: if (!enb || ((reached || maxHit) && (req_ns || pedPend_q))) state_d = ST_EW_YEL;
            ST_EW_YEL: if (reached) state_d = ST_EW_CLR;
            ST_EW_CLR: if (reached) state_d = enb ? ST_NS_GRN : ST_OFF;
            default:   state_d = ST_OFF;
        endcase
    end

    // A request arriving on the very edge that enters clearance is served by that clearance.
    always_comb begin
        pedPend_d = pedPend_q;
        walkAct_d = walkAct_q;
        if (ped_req && enb && !walkAct_q) begin
            pedPend_d = 1'b1;
        end
        if (isClear(state_d) && !isClear(state_q)) begin
            walkAct_d = pedPend_d;
            pedPend_d = 1'b0;
        end else if (isClear(state_q) && !isClear(state_d)) begin
            walkAct_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_OFF;
            pedPend_q <= 1'b0;
            walkAct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pedPend_q <= pedPend_d;
            walkAct_q <= walkAct_d;
        end
    end

    assign lamps     = decodeLamps(state_q);
    assign ns_red    = lamps.nsRed;
    assign ns_yellow = lamps.nsYellow;
    assign ns_green  = lamps.nsGreen;
    assign ew_red    = lamps.ewRed;
    assign ew_yellow = lamps.ewYellow;
    assign ew_green  = lamps.ewGreen;
    assign walk      = walkAct_q && isClear(state_q);
    assign state_out = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed, table-driven bench for intersection_ctrl: each row is one clock
// of inputs plus the state and walk expected right after that edge.
module tb_intersection_ctrl;

    logic       clk;
    logic       reset;
    logic       enb;
    logic       req_ns;
    logic       req_ew;
    logic       ped_req;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       walk;
    logic [2:0] state_out;

    typedef struct {
        logic       rstN;
        logic       enb;
        logic       reqNs;
        logic       reqEw;
        logic       ped;
        logic [2:0] expState;
        logic       expWalk;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   passes;

    intersection_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .enb      (enb),
        .req_ns   (req_ns),
        .req_ew   (req_ew),
        .ped_req  (ped_req),
        .ns_red   (ns_red),
        .ns_yellow(ns_yellow),
        .ns_green (ns_green),
        .ew_red   (ew_red),
        .ew_yellow(ew_yellow),
        .ew_green (ew_green),
        .walk     (walk),
        .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lamps {nsR,nsY,nsG,ewR,ewY,ewG} for a given state encoding.
    function automatic logic [5:0] expLamps(input logic [2:0] s);
        case (s)
            3'd1:    return 6'b001100;
            3'd2:    return 6'b010100;
            3'd3:    return 6'b100100;
            3'd4:    return 6'b100001;
            3'd5:    return 6'b100010;
            3'd6:    return 6'b100100;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic addVec(input logic r, input logic e, input logic rn, input logic re,
                          input logic p, input int n, input logic [2:0] s, input logic w);
        vec_t v;
        v.rstN = r; v.enb = e; v.reqNs = rn; v.reqEw = re; v.ped = p;
        v.expState = s; v.expWalk = w;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic rn,
                                 input logic re, input logic p);
        @(negedge clk);
        reset   = r;
        enb     = e;
        req_ns  = rn;
        req_ew  = re;
        ped_req = p;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] s, input logic w);
        logic [9:0] act;
        logic [9:0] exp;
        @(posedge clk);
        #1;
        act = {state_out, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
        exp = {s, expLamps(s), w};
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    initial begin
        logic found;
        checks  = 0;
        passes  = 0;
        reset   = 1'b0;
        enb     = 1'b0;
        req_ns  = 1'b0;
        req_ew  = 1'b0;
        ped_req = 1'b0;

        // Startup with req_ew held, full NS and EW cycle, then long rest in NS green.
        addVec(0, 0, 0, 0, 0,  3, 3'd0, 0);
        addVec(1, 1, 0, 1, 0,  2, 3'd6, 0);
        addVec(1, 1, 0, 1, 0,  8, 3'd1, 0);
        addVec(1, 1, 0, 1, 0,  3, 3'd2, 0);
        addVec(1, 1, 0, 1, 0,  2, 3'd3, 0);
        addVec(1, 1, 0, 1, 0,  3, 3'd4, 0);
        addVec(1, 1, 1, 1, 0,  5, 3'd4, 0);
        addVec(1, 1, 1, 1, 0,  3, 3'd5, 0);
        addVec(1, 1, 1, 1, 0,  2, 3'd6, 0);
        addVec(1, 1, 0, 0, 0, 66, 3'd1, 0);
        addVec(1, 1, 0, 1, 0,  3, 3'd2, 0);
        addVec(1, 1, 0, 1, 0,  2, 3'd3, 0);
        addVec(1, 1, 0, 1, 0,  1, 3'd4, 0);
        // Pedestrian pulse in NS green, walk clearance, ped ignored during walk.
        addVec(0, 0, 0, 0, 0,  1, 3'd0, 0);
        addVec(1, 1, 0, 0, 0,  2, 3'd6, 0);
        addVec(1, 1, 0, 0, 0,  1, 3'd1, 0);
        addVec(1, 1, 0, 0, 1,  1, 3'd1, 0);
        addVec(1, 1, 0, 0, 0,  6, 3'd1, 0);
        addVec(1, 1, 0, 0, 0,  3, 3'd2, 0);
        addVec(1, 1, 0, 0, 0,  1, 3'd3, 1);
        addVec(1, 1, 0, 0, 1,  1, 3'd3, 1);
        addVec(1, 1, 0, 0, 0,  4, 3'd3, 1);
        addVec(1, 1, 0, 0, 0, 10, 3'd4, 0);
        // Shutdown from green, restart, and enb reasserted during yellow.
        addVec(0, 0, 0, 0, 0,  1, 3'd0, 0);
        addVec(1, 0, 0, 0, 1,  1, 3'd0, 0);
        addVec(1, 1, 0, 0, 0,  2, 3'd6, 0);
        addVec(1, 1, 0, 0, 0,  4, 3'd1, 0);
        addVec(1, 0, 0, 0, 0,  3, 3'd2, 0);
        addVec(1, 0, 0, 0, 0,  2, 3'd3, 0);
        addVec(1, 0, 0, 0, 0,  2, 3'd0, 0);
        addVec(1, 1, 0, 0, 0,  2, 3'd6, 0);
        addVec(1, 1, 0, 0, 0,  3, 3'd1, 0);
        addVec(1, 0, 0, 0, 0,  1, 3'd2, 0);
        addVec(1, 1, 0, 0, 0,  2, 3'd2, 0);
        addVec(1, 1, 0, 0, 0,  2, 3'd3, 0);
        addVec(1, 1, 0, 0, 0,  2, 3'd4, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].enb, vecs[i].reqNs, vecs[i].reqEw, vecs[i].ped);
            checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expWalk);
        end

        // Reset asserted in the middle of a walk clearance.
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("hsReset", 3'd0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("hsStart0", 3'd6, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("hsStart1", 3'd6, 0);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("hsGreenPed", 3'd1, 0);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            applyStimulus(1, 1, 0, 0, 0);
            @(posedge clk);
            #1;
            if (state_out == 3'd3) found = 1'b1;
        end
        checks++;
        if (found) passes++;
        else $display("[TB] FAIL hsReachClr: state %0d, expected 3 within 30 cycles", state_out);
        checks++;
        if (walk === 1'b1) passes++;
        else $display("[TB] FAIL hsWalkOn: walk %b, expected 1", walk);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("hsWalk2", 3'd3, 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("hsResetInWalk", 3'd0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("hsStayOff", 3'd0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
